// File: rtl/reduction_adder.sv
// Adder-tree reduction stage: sums each group of REDUCTION adjacent input words into one output word.
// Define REDUCTION_ADDER_PIPE_EN for a two-stage version (pairwise partial sums, then final sums).
module reduction_adder #(
  parameter int IN_WORD_WIDTH  = 32,
  parameter int OUT_WORD_WIDTH = 32,
  parameter int IN_BLOCKS      = 32,
  parameter int REDUCTION      = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              en,
  input  logic [IN_WORD_WIDTH*IN_BLOCKS-1:0]                din,
  output logic                                              dout_valid,
  output logic [OUT_WORD_WIDTH*(IN_BLOCKS/REDUCTION)-1:0]   dout
);

  localparam int N_GROUPS = IN_BLOCKS / REDUCTION;
  localparam int SUM_W    = IN_WORD_WIDTH + $clog2(REDUCTION);
  localparam int OUT_W    = OUT_WORD_WIDTH * N_GROUPS;

  if (REDUCTION < 1) begin : g_bad_reduction
    $fatal(1, "reduction_adder: REDUCTION must be >= 1");
  end else if ((IN_BLOCKS % REDUCTION) != 0 || IN_BLOCKS < 1) begin : g_bad_blocks
    $fatal(1, "reduction_adder: IN_BLOCKS must be a positive multiple of REDUCTION");
  end

  // Valid semantics: dout_valid is a one-cycle strobe per accepted en, in order.
  // There is no ready; the consumer must take every strobe.
  logic             load;
  logic [OUT_W-1:0] sums;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;

`ifdef REDUCTION_ADDER_PIPE_EN
  localparam int N_PAIRS = (REDUCTION + 1) / 2;
  localparam int PAIR_W  = IN_WORD_WIDTH + 1;
  localparam int PART_W  = PAIR_W * N_PAIRS * N_GROUPS;

  // Extra zero word lets the odd-REDUCTION partner index stay in range.
  logic [IN_WORD_WIDTH*(IN_BLOCKS+1)-1:0] din_ext;
  logic [PART_W-1:0]                      part_q, part_d;
  logic                                   stage1_valid_q;

  assign din_ext = {{IN_WORD_WIDTH{1'b0}}, din};

  always_comb begin
    part_d = part_q;
    if (en) begin
      for (int g = 0; g < N_GROUPS; g++) begin
        for (int p = 0; p < N_PAIRS; p++) begin
          part_d[(g*N_PAIRS+p)*PAIR_W +: PAIR_W] =
            PAIR_W'(din_ext[(g*REDUCTION+2*p)*IN_WORD_WIDTH +: IN_WORD_WIDTH]) +
            ((2*p+1 < REDUCTION) ?
              PAIR_W'(din_ext[(g*REDUCTION+2*p+1)*IN_WORD_WIDTH +: IN_WORD_WIDTH]) :
              PAIR_W'(0));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q         <= '0;
      stage1_valid_q <= 1'b0;
    end else begin
      part_q         <= part_d;
      stage1_valid_q <= en;
    end
  end

  always_comb begin
    logic [SUM_W-1:0] acc;
    acc  = '0;
    sums = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      acc = '0;
      for (int p = 0; p < N_PAIRS; p++) begin
        acc = acc + SUM_W'(part_q[(g*N_PAIRS+p)*PAIR_W +: PAIR_W]);
      end
      sums[g*OUT_WORD_WIDTH +: OUT_WORD_WIDTH] = OUT_WORD_WIDTH'(acc);
    end
  end

  assign load = stage1_valid_q;
`else
  // Full-precision group sum, then truncate or zero-extend to the output word.
  always_comb begin
    logic [SUM_W-1:0] acc;
    acc  = '0;
    sums = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      acc = '0;
      for (int r = 0; r < REDUCTION; r++) begin
        acc = acc + SUM_W'(din[(g*REDUCTION+r)*IN_WORD_WIDTH +: IN_WORD_WIDTH]);
      end
      sums[g*OUT_WORD_WIDTH +: OUT_WORD_WIDTH] = OUT_WORD_WIDTH'(acc);
    end
  end

  assign load = en;
`endif

  always_comb begin
    dout_d  = load ? sums : dout_q;
    valid_d = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_reduction_adder.sv
// Bench for reduction_adder: table-driven vectors on several configurations plus a
// randomized scoreboard on the 32-word, R=4 instance.
module tb_reduction_adder;

`ifdef REDUCTION_ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [255:0]  din_a = '0;  // 8 words, R=4
  logic [63:0]   din_b = '0;  // 2 words, R=2
  logic [1023:0] din_c = '0;  // 32 words, R=4
  logic [95:0]   din_d = '0;  // 3 words, R=3
  logic [63:0]   din_e = '0;  // 4x16-bit words, R=2, 8-bit out
  logic [15:0]   din_f = '0;  // 2x8-bit words, R=1, 12-bit out

  logic [63:0]  dout_a;
  logic [31:0]  dout_b;
  logic [255:0] dout_c;
  logic [31:0]  dout_d;
  logic [15:0]  dout_e;
  logic [23:0]  dout_f;
  logic dv_a, dv_b, dv_c, dv_d, dv_e, dv_f;

  reduction_adder #(.IN_WORD_WIDTH(32), .OUT_WORD_WIDTH(32), .IN_BLOCKS(8), .REDUCTION(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a), .dout_valid(dv_a), .dout(dout_a));
  reduction_adder #(.IN_WORD_WIDTH(32), .OUT_WORD_WIDTH(32), .IN_BLOCKS(2), .REDUCTION(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b), .dout_valid(dv_b), .dout(dout_b));
  reduction_adder #(.IN_WORD_WIDTH(32), .OUT_WORD_WIDTH(32), .IN_BLOCKS(32), .REDUCTION(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_c), .dout_valid(dv_c), .dout(dout_c));
  reduction_adder #(.IN_WORD_WIDTH(32), .OUT_WORD_WIDTH(32), .IN_BLOCKS(3), .REDUCTION(3)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_d), .dout_valid(dv_d), .dout(dout_d));
  reduction_adder #(.IN_WORD_WIDTH(16), .OUT_WORD_WIDTH(8), .IN_BLOCKS(4), .REDUCTION(2)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_e), .dout_valid(dv_e), .dout(dout_e));
  reduction_adder #(.IN_WORD_WIDTH(8), .OUT_WORD_WIDTH(12), .IN_BLOCKS(2), .REDUCTION(1)) u_f (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_f), .dout_valid(dv_f), .dout(dout_f));

  logic [255:0] dout_pad [6];
  logic [5:0]   dv_all;
  assign dout_pad[0] = 256'(dout_a);
  assign dout_pad[1] = 256'(dout_b);
  assign dout_pad[2] = dout_c;
  assign dout_pad[3] = 256'(dout_d);
  assign dout_pad[4] = 256'(dout_e);
  assign dout_pad[5] = 256'(dout_f);
  assign dv_all = {dv_f, dv_e, dv_d, dv_c, dv_b, dv_a};

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard for u_c: expected sums in order, en history for valid timing.
  logic [255:0] exp_q[$];
  logic         vq[$];
  logic [255:0] last_c = '0;

  function automatic logic [255:0] model_c(input logic [1023:0] d);
    logic [255:0] r;
    longint unsigned s;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += longint'(d[(g*4+k)*32 +: 32]);
      r[g*32 +: 32] = 32'(s % (64'd1 << 32));
    end
    return r;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    vq.delete();
    last_c = '0;
  endtask

  // One clock: record stimulus, advance to just after the edge, check u_c.
  task automatic cycle();
    logic exp_v;
    vq.push_back(en);
    if (en) exp_q.push_back(model_c(din_c));
    @(posedge clk);
    #1;
    exp_v = (vq.size() >= LAT) ? vq[vq.size()-LAT] : 1'b0;
    while (vq.size() > LAT) void'(vq.pop_front());
    chk("c_valid", 256'(dv_c), 256'(exp_v));
    if (exp_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL c_queue act=valid exp=no_pending_result");
      end else begin
        last_c = exp_q.pop_front();
      end
    end
    chk("c_dout", dout_c, last_c);
  endtask

  // ---------------- driver helpers ----------------
  task automatic rand_c();
    for (int k = 0; k < 32; k++) din_c[k*32 +: 32] = $urandom();
  endtask

  task automatic set_din(input int u, input logic [1023:0] d);
    case (u)
      0: din_a = d[255:0];
      1: din_b = d[63:0];
      3: din_d = d[95:0];
      4: din_e = d[63:0];
      5: din_f = d[15:0];
      default: din_c = d;
    endcase
  endtask

  typedef struct {
    int            unit;
    logic [1023:0] din;
    logic [255:0]  exp;
  } vec_t;

  localparam int N_VEC = 9;
  vec_t vecs [N_VEC];

  initial begin
    vecs[0] = '{0, 1024'({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}),
                256'({32'd26, 32'd10})};
    vecs[1] = '{0, 1024'({8{32'hFFFF_FFFF}}), 256'({2{32'hFFFF_FFFC}})};
    vecs[2] = '{0, 1024'({32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1, {4{32'h8000_0000}}}),
                256'({32'd5, 32'd0})};
    vecs[3] = '{1, 1024'({32'hFFFF_FFFF, 32'h0000_0002}), 256'(32'h0000_0001)};
    vecs[4] = '{1, 1024'({32'h1234_5678, 32'h1111_1111}), 256'(32'h2345_6789)};
    vecs[5] = '{3, 1024'({32'd7, 32'd6, 32'd5}), 256'(32'd18)};
    vecs[6] = '{3, 1024'({3{32'hFFFF_FFFF}}), 256'(32'hFFFF_FFFD)};
    vecs[7] = '{4, 1024'({16'h0001, 16'hFFFF, 16'h01FF, 16'h0003}), 256'({8'h00, 8'h02})};
    vecs[8] = '{5, 1024'({8'hA5, 8'hFF}), 256'({12'h0A5, 12'h0FF})};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 6; u++) begin
      chk($sformatf("rst_dout_%0d", u), dout_pad[u], '0);
    end
    chk("rst_valid", 256'(dv_all), '0);
    rst_n = 1'b1;
    flush_model();

    // table-driven vectors
    for (int i = 0; i < N_VEC; i++) begin
      set_din(vecs[i].unit, vecs[i].din);
      rand_c();
      en = 1'b1;
      cycle();
      en = 1'b0;
      repeat (LAT-1) cycle();
      chk($sformatf("vec%0d_valid", i), 256'(dv_all[vecs[i].unit]), 256'(1));
      chk($sformatf("vec%0d_dout", i), dout_pad[vecs[i].unit], vecs[i].exp);
      rand_c();
      cycle();
      chk($sformatf("vec%0d_valid_drop", i), 256'(dv_all[vecs[i].unit]), 256'(0));
      chk($sformatf("vec%0d_hold", i), dout_pad[vecs[i].unit], vecs[i].exp);
    end

    // streaming: three back-to-back vectors
    din_c = {32{32'd1}};
    en = 1'b1;
    cycle();
    din_c = {32{32'd2}};
    cycle();
    din_c = {32{32'd3}};
    cycle();
    en = 1'b0;
    repeat (LAT) cycle();
    chk("stream_last", dout_c, {8{32'd12}});
    chk("stream_queue_empty", 256'(exp_q.size()), 256'(0));

    // idle hold with toggling inputs
    for (int k = 0; k < 10; k++) begin
      rand_c();
      din_a = {8{$urandom()}};
      cycle();
    end
    chk("idle_hold", dout_c, {8{32'd12}});

    // asynchronous reset while a result is valid
    din_a = 256'({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    en = 1'b1;
    cycle();
    en = 1'b0;
    repeat (LAT-1) cycle();
    chk("pre_rst_valid", 256'(dv_a), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 256'(dv_all), '0);
    chk("async_rst_dout_a", dout_pad[0], '0);
    chk("async_rst_dout_c", dout_pad[2], '0);
    #1 rst_n = 1'b1;
    flush_model();
    repeat (3) cycle();
    chk("post_rst_dout_a", dout_pad[0], '0);
    chk("post_rst_valid_a", 256'(dv_a), '0);

    // reset with a vector in flight: nothing may emerge afterwards
    rand_c();
    en = 1'b1;
    cycle();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    flush_model();
    repeat (LAT + 2) cycle();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rand_c();
      en = ($urandom_range(0, 3) != 0);
      cycle();
    end
    en = 1'b0;
    repeat (LAT + 1) cycle();
    chk("rand_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
